// File: rtl/window_generator.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register
// present the neighbourhood of every interior pixel of a raster-order frame.
module window_generator #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    input  logic              stall,
    output logic              pix_ready,
    output logic signed [8:0] img [9],
    output logic              win_valid,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      win_q [9];
    logic [7:0]      win_d [9];
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q, frame_done_d;

    logic [7:0]      lb1_q [IMG_WIDTH];
    logic [7:0]      lb2_q [IMG_WIDTH];
    logic [7:0]      lb1_rd, lb2_rd;
    logic            accept, col_last, row_last;

    assign pix_ready = !stall && !reset;
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last  = (row_q == RW'(IMG_HEIGHT - 1));
    assign lb1_rd    = lb1_q[col_q];
    assign lb2_rd    = lb2_q[col_q];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = lb2_rd;
            win_d[5] = lb1_rd;
            win_d[8] = pix_in;

            // The accepted pixel's own row/column decide validity, not the next ones.
            win_valid_d = (state_q == RUN) && (col_q >= CW'(2));

            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = FILL;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q == RW'(1)) begin
                        state_d = RUN;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (!stall) begin
            win_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: 8'h00};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: line buffers carry no reset; every window reads only entries written this frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= pix_in;
            lb2_q[col_q] <= lb1_rd;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            img[k] = $signed({1'b0, win_q[k]});
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: a 4x4 and an 8x8 instance share the
// stimulus; a reference 3x3 extraction predicts every acceptance edge.
module tb_window_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       stall;
    logic       sel8;

    logic              pr4, wv4, fd4, pr8, wv8, fd8;
    logic signed [8:0] img4 [9];
    logic signed [8:0] img8 [9];

    always #5 clk = ~clk;

    window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .stall(stall),
        .pix_ready(pr4), .img(img4), .win_valid(wv4), .frame_done(fd4)
    );

    window_generator #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .stall(stall),
        .pix_ready(pr8), .img(img8), .win_valid(wv8), .frame_done(fd8)
    );

    typedef struct packed {
        logic            has_win;
        logic            last;
        logic [8:0][7:0] win;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_win = 0;
    int   n_fd = 0;
    int   cur_w = 4;
    int   cur_h = 4;
    int   mrow = 0;
    int   mcol = 0;
    logic [7:0] frame_m [8][8];

    logic            first_pending = 1'b0;
    logic [8:0][8:0] first_win, last_win;
    logic [8:0][8:0] prev_img, act_img;
    logic            prev_wv;
    logic            m_acc, m_stall, m_rst, exp_wv;
    logic            wv_m, fd_m, pr_m;
    exp_t            m_e;

    function automatic logic [8:0][8:0] exp_ramp(input int b);
        logic [8:0][8:0] r;
        for (int k = 0; k < 9; k++) r[k] = 9'(b + (k / 3) * 4 + k % 3);
        return r;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        m_acc   = pix_valid && !stall && !reset;
        m_stall = stall;
        m_rst   = reset;
        #1;
        wv_m = sel8 ? wv8 : wv4;
        fd_m = sel8 ? fd8 : fd4;
        pr_m = sel8 ? pr8 : pr4;
        for (int k = 0; k < 9; k++) act_img[k] = sel8 ? img8[k] : img4[k];
        if (m_rst || reset) begin
            prev_img = '0;
            prev_wv  = 1'b0;
        end else begin
            n_vec++;
            if (pr_m !== !stall) begin
                n_fail++;
                $display("FAIL pix_ready: got %b expected %b", pr_m, !stall);
            end
            if (m_acc) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow: acceptance with no prediction");
                end else begin
                    m_e = exp_q.pop_front();
                    n_vec++;
                    if (wv_m !== m_e.has_win) begin
                        n_fail++;
                        $display("FAIL win_valid_accept: got %b expected %b", wv_m, m_e.has_win);
                    end
                    if (m_e.has_win) begin
                        logic [8:0][8:0] ew;
                        for (int k = 0; k < 9; k++) ew[k] = {1'b0, m_e.win[k]};
                        n_vec++;
                        if (act_img !== ew) begin
                            n_fail++;
                            $display("FAIL window: got %h expected %h", act_img, ew);
                        end
                        n_win++;
                        last_win = act_img;
                        if (first_pending) begin
                            first_win     = act_img;
                            first_pending = 1'b0;
                        end
                    end
                    n_vec++;
                    if (fd_m !== m_e.last) begin
                        n_fail++;
                        $display("FAIL frame_done_accept: got %b expected %b", fd_m, m_e.last);
                    end
                end
            end else begin
                exp_wv = m_stall ? prev_wv : 1'b0;
                n_vec++;
                if (fd_m !== 1'b0) begin
                    n_fail++;
                    $display("FAIL frame_done_idle: got %b expected 0", fd_m);
                end
                n_vec++;
                if (act_img !== prev_img) begin
                    n_fail++;
                    $display("FAIL img_hold: got %h expected %h", act_img, prev_img);
                end
                n_vec++;
                if (wv_m !== exp_wv) begin
                    n_fail++;
                    $display("FAIL win_valid_idle: got %b expected %b", wv_m, exp_wv);
                end
            end
            if (fd_m === 1'b1) n_fd++;
            prev_img = act_img;
            prev_wv  = wv_m;
        end
    end

    // Drives one cycle starting just after a falling edge; predicts the acceptance outcome.
    task automatic drive(input logic v, input logic s, input logic [7:0] p);
        exp_t e;
        pix_valid = v;
        stall     = s;
        pix_in    = p;
        if (v && !s) begin
            frame_m[mrow][mcol] = p;
            e.has_win = (mrow >= 2) && (mcol >= 2);
            e.last    = (mrow == cur_h - 1) && (mcol == cur_w - 1);
            e.win     = '0;
            if (e.has_win) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        e.win[dr*3 + dc] = frame_m[mrow - 2 + dr][mcol - 2 + dc];
            end
            exp_q.push_back(e);
            if (mcol == cur_w - 1) begin
                mcol = 0;
                mrow = (mrow == cur_h - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        stall     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mrow  = 0;
        mcol  = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [8:0][8:0] z;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(i + 20));
        pix_valid = 1'b1;
        stall     = 1'b0;
        #2 reset  = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) z[k] = img4[k];
        n_vec++;
        if (z !== '0) begin
            n_fail++;
            $display("FAIL reset_img: got %h expected 0", z);
        end
        n_vec++;
        if ({wv4, fd4, pr4} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got wv/fd/rdy %b expected 000", {wv4, fd4, pr4});
        end
        @(negedge clk);
        reset = 1'b0;
        mrow  = 0;
        mcol  = 0;
        exp_q.delete();
        pix_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int w0 = n_win;
        int f0 = n_fd;
        first_pending = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (n_win - w0 != 4 || n_fd - f0 != 1) begin
            n_fail++;
            $display("FAIL ramp_counts: got %0d windows %0d done expected 4 1", n_win - w0, n_fd - f0);
        end
        n_vec++;
        if (first_win !== exp_ramp(0)) begin
            n_fail++;
            $display("FAIL ramp_first: got %h expected %h", first_win, exp_ramp(0));
        end
        n_vec++;
        if (last_win !== exp_ramp(5)) begin
            n_fail++;
            $display("FAIL ramp_last: got %h expected %h", last_win, exp_ramp(5));
        end
    endtask

    task automatic test_stall();
        int w0 = n_win;
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'd11);
        first_pending = 1'b1;
        for (int i = 11; i < 16; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (first_win !== exp_ramp(1)) begin
            n_fail++;
            $display("FAIL stall_release_window: got %h expected %h", first_win, exp_ramp(1));
        end
        n_vec++;
        if (n_win - w0 != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected 4", n_win - w0);
        end
    endtask

    task automatic test_bubbles();
        int w0 = n_win;
        first_pending = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            drive(1'b0, 1'b0, 8'hAA);
        end
        n_vec++;
        if (n_win - w0 != 4 || first_win !== exp_ramp(0) || last_win !== exp_ramp(5)) begin
            n_fail++;
            $display("FAIL bubbles: got %0d windows first %h last %h expected 4 %h %h",
                     n_win - w0, first_win, last_win, exp_ramp(0), exp_ramp(5));
        end
    endtask

    task automatic test_back_to_back();
        int w0 = n_win;
        int f0 = n_fd;
        logic [8:0][8:0] all255;
        for (int k = 0; k < 9; k++) all255[k] = 9'h0FF;
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 8'hFF);
        n_vec++;
        if (last_win !== all255) begin
            n_fail++;
            $display("FAIL all255: got %h expected %h", last_win, all255);
        end
        first_pending = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (n_win - w0 != 12 || n_fd - f0 != 3) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d windows %0d done expected 12 3", n_win - w0, n_fd - f0);
        end
        n_vec++;
        if (first_win !== exp_ramp(0)) begin
            n_fail++;
            $display("FAIL b2b_stale: got %h expected %h", first_win, exp_ramp(0));
        end
    endtask

    task automatic test_reset_midframe();
        int w0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
        do_reset();
        w0 = n_win;
        first_pending = 1'b1;
        for (int i = 100; i < 116; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (first_win !== exp_ramp(100) || n_win - w0 != 4) begin
            n_fail++;
            $display("FAIL reset_midframe: got %h (%0d windows) expected %h (4)",
                     first_win, n_win - w0, exp_ramp(100));
        end
    endtask

    task automatic test_random();
        int w0, f0, acc_cnt;
        sel8  = 1'b1;
        cur_w = 8;
        cur_h = 8;
        do_reset();
        w0 = n_win;
        f0 = n_fd;
        for (int f = 0; f < 2; f++) begin
            acc_cnt = 0;
            for (int it = 0; it < 2000 && acc_cnt < 64; it++) begin
                logic v, s;
                v = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 3) == 0);
                if (v && !s) acc_cnt++;
                drive(v, s, 8'($urandom_range(0, 255)));
            end
            n_vec++;
            if (acc_cnt != 64) begin
                n_fail++;
                $display("FAIL random_budget: got %0d pixels expected 64", acc_cnt);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (n_win - w0 != 72 || n_fd - f0 != 2) begin
            n_fail++;
            $display("FAIL random_counts: got %0d windows %0d done expected 72 2", n_win - w0, n_fd - f0);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        pix_valid = 1'b0;
        stall     = 1'b0;
        pix_in    = 8'h00;
        sel8      = 1'b0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_ramp();
        test_stall();
        test_bubbles();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
- REQ-001: Parameter IMG_WIDTH, default 8: pixels per line; legal range 3..1024.
- REQ-002: Parameter IMG_HEIGHT, default 8: lines per frame; legal range 3..1024.
- REQ-003: Port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004: Port reset, input, 1: asynchronous, active-high reset.
- REQ-005: Port pix_in, input, 8: unsigned raster-order pixel.
- REQ-006: Port pix_valid, input, 1: pix_in carries a pixel this cycle.
- REQ-007: Port stall, input, 1: downstream convolution stage is holding.
- REQ-008: Port pix_ready, output, 1: block accepts a pixel this cycle.
- REQ-009: Port img, output, 9x9 signed array img[8:0]: 3x3 window, row-major; img[0] top-left, img[8] bottom-right (newest pixel).
- REQ-010: Port win_valid, output, 1: img holds a complete, new window.
- REQ-011: Port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

Function
- REQ-012: pix_ready SHALL equal !stall combinationally, and SHALL be 0 while reset is asserted.
- REQ-013: A pixel SHALL be accepted on a rising edge where pix_valid && pix_ready; no other edge changes line buffers, counters or the window.
- REQ-014: col counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) SHALL advance per accepted pixel; col wraps to 0 and row increments at col==IMG_WIDTH-1.
- REQ-015: Two line buffers of IMG_WIDTH x 8 bits SHALL hold rows r-1 and r-2; on acceptance at column c, lb1[c] <= pix_in and lb2[c] <= old lb1[c].
- REQ-016: On acceptance, the 3x3 window register SHALL shift left one column and load the new right column {top=old lb2[c], mid=old lb1[c], bottom=pix_in}.
- REQ-017: Each img element SHALL be the pixel zero-extended to 9 bits (sign bit 0, range 0..255).
- REQ-018: State machine: FILL (row<2) and RUN (row>=2); FILL->RUN on acceptance of the last pixel of row 1; RUN->FILL on acceptance of the last pixel of the frame.
- REQ-019: win_valid SHALL be registered: set on an acceptance edge where state is RUN and the accepted pixel's col>=2; cleared on an acceptance edge otherwise.
- REQ-020: Latency: the window whose bottom-right is the pixel accepted at edge N SHALL be on img with win_valid=1 immediately after edge N.
- REQ-021: When stall=1, img and win_valid SHALL hold their values; when stall=0 and no pixel is accepted, win_valid SHALL clear to 0 on that edge and img SHALL hold.
- REQ-022: Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows SHALL be emitted per frame; no padding windows at borders.
- REQ-023: frame_done SHALL be 1 for exactly the cycle after acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), even when stall rises that cycle; counters return to 0 on the same edge.
- REQ-024: A following frame SHALL start without idle cycles; stale line buffer contents SHALL never appear in a valid window.

Reset
- REQ-025: While reset is asserted, asynchronously: col=0, row=0, state=FILL, all img elements=0, win_valid=0, frame_done=0.
- REQ-026: Line buffer contents need not be reset.
- REQ-027: Reset asserted mid-frame SHALL abandon the frame; the first pixel after deassertion is pixel (0,0) of a new frame.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4 unless noted)
- REQ-028: Ramp 0..15, pix_valid=1, stall=0 -> exactly 4 windows, after pixels 10, 11, 14, 15; first img={0,1,2,4,5,6,8,9,10}, last img={5,6,7,9,10,11,13,14,15}; frame_done pulses once after pixel 15.
- REQ-029: Same ramp, stall=1 for 3 cycles right after window for pixel 10 -> pix_ready=0, img and win_valid=1 held; pixel 11 accepted after release, window {1,2,3,5,6,7,9,10,11}.
- REQ-030: Ramp with pix_valid=0 inserted every other cycle -> win_valid 1-cycle pulses, identical window sequence to REQ-028.
- REQ-031: Frame of all 255 -> every img element 9'sd255 (positive); two back-to-back frames -> 8 windows, 2 frame_done pulses, second frame's first window only after its pixel 10.
- REQ-032: Reset asserted after pixel 9, deasserted, new ramp 100..115 -> no window before pixel 110; first img={100,101,102,104,105,106,108,109,110}.
- REQ-033: Defaults 8x8, random pixels with random pix_valid/stall -> 36 windows per frame, each matching a reference 3x3 extraction.
